mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single-ported unified instruction/data memory of the multi-cycle CPU. It shares the one memory port between the instruction-fetch requester (`if_`) and the load/store requester (`d_`). It issues one access at a time and waits out the fixed memory read latency. It routes read data back to the requester that owns the access. Priority is fixed with data first, plus a starvation guard for fetch.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, load/store and memory-port signals for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one unified memory port between fetch and load/store,
//               data-first priority with a fetch starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // The grant cycle is the first latency cycle, so WAIT covers MEM_LAT-1 cycles.
    localparam logic [1:0] WAIT_LAST  = 2'(MEM_LAT >= 2 ? MEM_LAT - 2 : 0);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state;
    owner_t      owner;
    logic [1:0]  lat_cnt;
    logic [3:0]  starve_cnt;

    logic        fetch_win;
    logic        data_win;
    logic        if_resp;
    logic        d_resp;

    always_comb begin
        fetch_win = 1'b0;
        data_win  = 1'b0;
        if (state == ST_IDLE && !reset) begin
            if (bus.if_req && starve_cnt == STARVE_LIM) begin
                fetch_win = 1'b1;
            end else if (bus.d_req) begin
                data_win = 1'b1;
            end else if (bus.if_req) begin
                fetch_win = 1'b1;
            end
        end
    end

    assign bus.if_gnt    = fetch_win;
    assign bus.d_gnt     = data_win;
    assign bus.mem_en    = fetch_win | data_win;
    assign bus.mem_we    = data_win & bus.d_we;
    assign bus.mem_addr  = fetch_win ? bus.if_addr :
                           data_win  ? bus.d_addr  : {ADDR_W{1'b0}};
    assign bus.mem_wdata = data_win ? bus.d_wdata : {DATA_W{1'b0}};
    assign bus.mem_wstrb = (data_win && bus.d_we) ? bus.d_wstrb : {(DATA_W/8){1'b0}};

    assign if_resp       = (state == ST_RESP) && (owner == OWN_IF);
    assign d_resp        = (state == ST_RESP) && (owner == OWN_D);
    assign bus.if_rvalid = if_resp;
    assign bus.d_rvalid  = d_resp;
    assign bus.if_rdata  = if_resp ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.d_rdata   = d_resp  ? bus.mem_rdata : {DATA_W{1'b0}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= OWN_IF;
            lat_cnt    <= 2'd0;
            starve_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Writes complete in the grant cycle and leave the port free.
                    if (fetch_win || (data_win && !bus.d_we)) begin
                        owner   <= fetch_win ? OWN_IF : OWN_D;
                        lat_cnt <= 2'd0;
                        state   <= (MEM_LAT == 1) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt + 2'd1;
                    if (lat_cnt == WAIT_LAST) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (!bus.if_req || fetch_win) begin
                starve_cnt <= 4'd0;
            end else if (data_win && starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed bench for mem_port_arbiter with a 2-cycle memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word array, byte-strobed writes, two-stage read pipeline.
    logic [31:0] mem [0:255];
    logic [31:0] pipe0;
    logic [31:0] pipe1;

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wstrb[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
        pipe0 <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[9:2]] : 32'h0;
        pipe1 <= pipe0;
    end
    assign bus.mem_rdata = pipe1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'h00500093;   // 0x40
        mem[8'h20] = 32'hCAFEF00D;   // 0x80
        mem[8'h40] = 32'h12345678;   // 0x100
        mem[8'h80] = 32'hA5A5A5A5;   // 0x200
        pipe0 = 32'h0;
        pipe1 = 32'h0;

        reset       = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h40;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h100;
        bus.d_wdata = 32'h0;
        bus.d_wstrb = 4'h0;

        // Reset held three cycles with both requests pending
        for (int i = 0; i < 3; i++) begin
            cyc(); settle();
            chk("rst_ctrl", {26'h0, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we,
                             bus.if_rvalid, bus.d_rvalid}, 32'h0);
            chk("rst_addr", bus.mem_addr, 32'h0);
            chk("rst_rdata", bus.if_rdata | bus.d_rdata, 32'h0);
        end

        // First cycle after release: data read to 0x100 wins
        cyc(); reset = 1'b0; settle();
        chk("rel_dgnt", {30'h0, bus.d_gnt, bus.if_gnt}, 32'h2);
        chk("rel_addr", bus.mem_addr, 32'h100);
        cyc(); bus.d_req = 1'b0; settle();
        chk("wait_nogrant", {30'h0, bus.d_gnt, bus.if_gnt}, 32'h0);
        cyc(); settle();
        chk("rel_drvalid", {30'h0, bus.d_rvalid, bus.if_rvalid}, 32'h2);
        chk("rel_drdata", bus.d_rdata, 32'h12345678);

        // Single fetch at 0x40 (grant T)
        cyc(); settle();
        chk("fetch_gnt", {30'h0, bus.if_gnt, bus.mem_en}, 32'h3);
        chk("fetch_addr", bus.mem_addr, 32'h40);
        chk("fetch_we", {28'h0, bus.mem_wstrb}, 32'h0);
        cyc(); bus.if_req = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200;
        bus.d_wdata = 32'hDEADBEEF; bus.d_wstrb = 4'b0011; settle();
        chk("fetch_t1_nogrant", {31'h0, bus.d_gnt}, 32'h0);
        cyc(); settle();
        chk("fetch_rvalid", {30'h0, bus.if_rvalid, bus.d_rvalid}, 32'h2);
        chk("fetch_rdata", bus.if_rdata, 32'h00500093);
        chk("fetch_t2_nogrant", {31'h0, bus.d_gnt}, 32'h0);

        // Write with strobes at T+3
        cyc(); settle();
        chk("wr_gnt", {29'h0, bus.d_gnt, bus.mem_en, bus.mem_we}, 32'h7);
        chk("wr_strb", {28'h0, bus.mem_wstrb}, 32'h3);
        chk("wr_data", bus.mem_wdata, 32'hDEADBEEF);
        chk("wr_addr", bus.mem_addr, 32'h200);
        cyc(); bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wstrb = 4'h0; settle();
        chk("wr_no_rvalid1", {31'h0, bus.d_rvalid}, 32'h0);
        cyc(); settle();
        chk("wr_no_rvalid2", {31'h0, bus.d_rvalid}, 32'h0);

        // Read-back of 0x200
        bus.d_req = 1'b1; settle();
        chk("rb_gnt", {30'h0, bus.d_gnt, bus.mem_we}, 32'h2);
        chk("rb_strb", {28'h0, bus.mem_wstrb}, 32'h0);
        cyc(); bus.d_req = 1'b0; settle();
        cyc(); settle();
        chk("rb_rvalid", {31'h0, bus.d_rvalid}, 32'h1);
        chk("rb_rdata", bus.d_rdata, 32'hA5A5BEEF);

        // Collision: fetch 0x80 against data read 0x100
        cyc(); bus.if_req = 1'b1; bus.if_addr = 32'h80;
        bus.d_req = 1'b1; bus.d_addr = 32'h100; settle();
        chk("col_gnt", {30'h0, bus.d_gnt, bus.if_gnt}, 32'h2);
        cyc(); bus.d_req = 1'b0; settle();
        chk("col_t1_nogrant", {31'h0, bus.if_gnt}, 32'h0);
        cyc(); settle();
        chk("col_drvalid", {30'h0, bus.d_rvalid, bus.if_rvalid}, 32'h2);
        chk("col_drdata", bus.d_rdata, 32'h12345678);
        cyc(); settle();
        chk("col_ifgnt", {30'h0, bus.if_gnt, bus.d_gnt}, 32'h2);
        chk("col_ifaddr", bus.mem_addr, 32'h80);
        cyc(); bus.if_req = 1'b0; settle();
        cyc(); settle();
        chk("col_ifrdata", bus.if_rdata, 32'hCAFEF00D);

        // Starvation: fetch held against back-to-back writes
        cyc(); bus.if_req = 1'b1; bus.if_addr = 32'h40;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h204;
        bus.d_wdata = 32'h11223344; bus.d_wstrb = 4'hF; settle();
        for (int i = 0; i < 4; i++) begin
            chk("stv_dgnt", {30'h0, bus.d_gnt, bus.if_gnt}, 32'h2);
            cyc(); settle();
        end
        chk("stv_ifgnt", {30'h0, bus.if_gnt, bus.d_gnt}, 32'h2);
        chk("stv_ifaddr", bus.mem_addr, 32'h40);
        cyc(); bus.if_req = 1'b0; settle();
        chk("stv_wait", {31'h0, bus.d_gnt}, 32'h0);
        cyc(); settle();
        chk("stv_rdata", bus.if_rdata, 32'h00500093);
        chk("stv_resp_nogrant", {31'h0, bus.d_gnt}, 32'h0);
        cyc(); settle();
        chk("stv_dresume", {31'h0, bus.d_gnt}, 32'h1);
        cyc(); bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wstrb = 4'h0; settle();

        // Reset during WAIT abandons the read
        bus.if_req = 1'b1; bus.if_addr = 32'h40; settle();
        chk("rw_gnt", {31'h0, bus.if_gnt}, 32'h1);
        cyc(); bus.if_req = 1'b0; reset = 1'b1; settle();
        chk("rw_in_reset", {30'h0, bus.if_rvalid, bus.mem_en}, 32'h0);
        cyc(); reset = 1'b0; settle();
        for (int i = 0; i < 4; i++) begin
            chk("rw_no_rvalid", {30'h0, bus.if_rvalid, bus.d_rvalid}, 32'h0);
            cyc(); settle();
        end
        bus.if_req = 1'b1; bus.if_addr = 32'h80; settle();
        chk("rw_new_gnt", {31'h0, bus.if_gnt}, 32'h1);
        cyc(); bus.if_req = 1'b0; settle();
        chk("rw_new_t1", {31'h0, bus.if_rvalid}, 32'h0);
        cyc(); settle();
        chk("rw_new_rvalid", {31'h0, bus.if_rvalid}, 32'h1);
        chk("rw_new_rdata", bus.if_rdata, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
